piso_frame_tx: RTL
==================

// Module: piso_frame_tx
// PURPOSE
//  Parallel-in/serial-out framed transmitter, the sending end of the team's DFF-chain serial receiver.
//  - Accepts one WIDTH-bit word over a valid/ready handshake.
//  - Shifts the word out on a single line: start bit, data bits, stop bit.
//  - Sits between a parallel producer (register file or counter) and an off-block serial wire.
// PARAMETERS
//  WIDTH         8  data bits per frame; legal range >= 1
//  CLKS_PER_BIT  1  clk cycles each serial bit is held; legal range >= 1
//  MSB_FIRST     1  1: data[WIDTH-1] is sent first; 0: data[0] is sent first
// PORTS
//  clk         in   1      clock; all state changes on posedge clk
//  rst         in   1      reset: asynchronous, active-high
//  load_valid  in   1      producer offers load_data this cycle
//  load_ready  out  1      transmitter can accept a word; high only in IDLE
//  load_data   in   WIDTH  word to send; sampled only on the accept cycle
//  sout        out  1      serial line; idle level is 1
//  busy        out  1      a frame is in progress (START, DATA or STOP)
//  done        out  1      one-cycle pulse after the last stop-bit cycle
// BEHAVIOUR
//  - Reset values: sout=1, load_ready=1, busy=0, done=0, state=IDLE, counters=0.
//  - Reset is asynchronous: sout returns to 1 immediately and a frame in flight is aborted; no done pulse.
//  - All outputs are registered (no combinational path from inputs to outputs).
//  - Accept: load_valid & load_ready at a posedge.
//    - load_data is captured into the shift register.
//    - state -> START; next cycle load_ready=0, busy=1.
//  - load_valid while not ready is ignored; load_data changes after accept have no effect.
//  - FSM states and transitions:
//    - IDLE:  sout=1. Go to START on accept.
//    - START: sout=0 for CLKS_PER_BIT cycles, then DATA.
//    - DATA:  sout = current shift bit, held CLKS_PER_BIT cycles per bit.
//      Shift left (MSB_FIRST=1) or right (MSB_FIRST=0) after each bit.
//      After WIDTH bits, go to STOP.
//    - STOP:  sout=1 for CLKS_PER_BIT cycles, then IDLE.
//  - Frame length: (WIDTH+2)*CLKS_PER_BIT cycles from the first start-bit cycle.
//  - On the cycle after the last stop-bit cycle:
//    - done=1 for exactly one cycle.
//    - busy=0, load_ready=1.
//  - Back-to-back: if load_valid is held high, the next accept happens in that ready cycle.
//    Minimum inter-frame gap is one idle cycle (sout=1).
//  - Counters:
//    - bit counter: $clog2(WIDTH+1) bits; counts 0..WIDTH-1, then wraps to 0.
//    - baud counter: max(1,$clog2(CLKS_PER_BIT)) bits; counts 0..CLKS_PER_BIT-1, then wraps to 0.
//    - Neither counter may overflow or free-run while in IDLE.
//  - WIDTH=1 and CLKS_PER_BIT=1 are legal and use the same FSM; there are no special-case states.
// STRUCTURE
//  - Package serial_pkg:
//    - tx_state_t enum {IDLE, START, DATA, STOP}.
//    - Constants START_LEVEL=1'b0, STOP_LEVEL=1'b1, IDLE_LEVEL=1'b1.
//    - Shared with the receiver.
//  - Sub-module baud_tick_gen #(CLKS_PER_BIT):
//    - Inputs: clk, rst, en.
//    - Output: tick, asserted on the last cycle of each bit period.
//    - Cleared whenever en=0.
//  - Top level holds the FSM, the shift register and the bit counter.
// TESTING
//  1 WIDTH=8, CPB=1, MSB_FIRST=1, send 8'hC5:
//    - sout from the cycle after accept = 0,1,1,0,0,0,1,0,1,1.
//    - done pulses at cycle 11.
//  2 Same as 1 with MSB_FIRST=0:
//    - sout = 0,1,0,1,0,0,0,1,1,1.
//  3 CPB=4, send 8'hFF:
//    - sout=0 for 4 cycles, then 1 for 36 cycles.
//    - busy high for 40 cycles; done at cycle 41.
//  4 load_valid held high with 8'h00 then 8'hFF:
//    - Exactly one sout=1 idle cycle between the first stop bit and the second start bit.
//    - Two done pulses.
//  5 Assert rst during data bit 3 of a frame:
//    - Immediately sout=1, busy=0, load_ready=1.
//    - No done pulse; the next frame is sent intact.
//  6 While busy, pulse load_valid with 8'h12 and change load_data:
//    - The current frame is unchanged.
//    - 8'h12 is never sent unless it is re-offered in IDLE.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared framing definitions for the serial transmitter and its matching receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: tick marks the last clk cycle of each serial bit.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Held at zero while disabled so every frame starts on a fresh bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!en || cnt == CNT_LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/piso_frame_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, WIDTH data bits, stop bit.
// state | meaning
// IDLE  | line at idle level, ready for a word
// START | start bit on the line
// DATA  | shifting data bits out
// STOP  | stop bit on the line, done follows
module piso_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  import serial_pkg::*;

  localparam int             BCW      = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

  tx_state_t        state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [BCW-1:0]   bit_cnt;
  logic             tick;
  logic             baud_en;
  logic             accept;
  logic             first_bit;
  logic             next_bit;

  assign accept    = load_valid && load_ready;
  assign baud_en   = (state != IDLE);
  assign shreg_nxt = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
  assign first_bit = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign next_bit  = (MSB_FIRST != 0) ? shreg_nxt[WIDTH-1] : shreg_nxt[0];

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (baud_en),
    .tick (tick)
  );

  // sout is loaded with the level of the state being entered, keeping it a pure flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      sout       <= IDLE_LEVEL;
      load_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg      <= load_data;
            state      <= START;
            sout       <= START_LEVEL;
            load_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            sout  <= first_bit;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= STOP;
              sout    <= STOP_LEVEL;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg_nxt;
              sout    <= next_bit;
            end
          end
        end
        STOP: begin
          if (tick) begin
            state      <= IDLE;
            sout       <= IDLE_LEVEL;
            busy       <= 1'b0;
            load_ready <= 1'b1;
            done       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
